// File: rtl/pio_edge_capture_in.sv
// Avalon-MM input PIO: synchronised input, per-bit edge detect, sticky W1C capture
// register and a masked level interrupt.
module pio_edge_capture_in #(
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            SYNC_STAGES = 2,
  parameter int unsigned            EDGE_TYPE   = 0,
  parameter logic [DATA_WIDTH-1:0]  RESET_MASK  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync_q;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] edge_raw;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] edge_capture;
  logic [DATA_WIDTH-1:0] capture_next;
  logic [DATA_WIDTH-1:0] irq_mask;
  logic [DATA_WIDTH-1:0] mask_next;
  logic [DATA_WIDTH-1:0] clr;
  logic [31:0]           rd_mux;
  logic [2:0]            warm_cnt;
  logic                  wr_en;

  assign sync_q = sync_r[SYNC_STAGES-1];
  assign wr_en  = chipselect & ~write_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_r[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      prev_q <= sync_q;
    end
  end

  // Warm-up holds off detection until the chain and prev_q hold real input,
  // so a level already high at reset is not seen as a rising edge.
  always_ff @(posedge clk) begin
    if (reset)               warm_cnt <= 3'(SYNC_STAGES + 1);
    else if (warm_cnt != '0) warm_cnt <= warm_cnt - 3'd1;
  end

  always_comb begin
    edge_raw = '0;
    case (EDGE_TYPE)
      0:       edge_raw = sync_q & ~prev_q;
      1:       edge_raw = ~sync_q & prev_q;
      default: edge_raw = sync_q ^ prev_q;
    endcase
    edge_det = (warm_cnt == '0) ? edge_raw : '0;
  end

  always_comb begin
    clr       = '0;
    mask_next = irq_mask;
    if (wr_en && address == 2'd3) clr       = writedata[DATA_WIDTH-1:0];
    if (wr_en && address == 2'd2) mask_next = writedata[DATA_WIDTH-1:0];
    // A fresh edge beats a clear of the same bit.
    capture_next = (edge_capture & ~clr) | edge_det;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[DATA_WIDTH-1:0] = sync_q;
      2'd2:    rd_mux[DATA_WIDTH-1:0] = irq_mask;
      2'd3:    rd_mux[DATA_WIDTH-1:0] = edge_capture;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_capture <= '0;
      irq_mask     <= RESET_MASK;
      readdata     <= '0;
      irq          <= 1'b0;
    end else begin
      edge_capture <= capture_next;
      irq_mask     <= mask_next;
      readdata     <= rd_mux;
      irq          <= |(capture_next & mask_next);
    end
  end

endmodule

// File: tb/tb_pio_edge_capture_in.sv
// Bench for pio_edge_capture_in: a 32-bit rising-edge instance and an 8-bit any-edge
// instance share the bus; a cycle model feeds a scoreboard, plus directed spot checks.
module tb_pio_edge_capture_in;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] in0 = '0;
  logic [7:0]  in1 = '0;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  pio_edge_capture_in #(.DATA_WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_MASK(32'h0)) dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0));

  pio_edge_capture_in #(.DATA_WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(2), .RESET_MASK(8'h0C)) dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in1), .readdata(rd1), .irq(irq1));

  typedef struct {
    logic [31:0] rd0;
    logic        irq0;
    logic [31:0] rd1;
    logic        irq1;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] m_sync [2][4];
  logic [31:0] m_prev [2];
  logic [31:0] m_ec   [2];
  logic [31:0] m_mask [2];
  int          m_warm [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_one(input int d, input int w, input int s, input int e,
                           input logic [31:0] rmask, input logic [31:0] inp,
                           output logic [31:0] rd, output logic irq_o);
    logic [31:0] wm, sq, ed, clr, ec_n, mask_n;
    logic        wr;
    wm = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    if (reset) begin
      for (int i = 0; i < 4; i++) m_sync[d][i] = '0;
      m_prev[d] = '0;
      m_ec[d]   = '0;
      m_mask[d] = rmask;
      m_warm[d] = s + 1;
      rd        = '0;
      irq_o     = 1'b0;
    end else begin
      sq = m_sync[d][s-1];
      case (e)
        0:       ed = sq & ~m_prev[d];
        1:       ed = ~sq & m_prev[d];
        default: ed = sq ^ m_prev[d];
      endcase
      ed = ed & wm;
      if (m_warm[d] != 0) ed = '0;
      wr     = chipselect && !write_n;
      clr    = (wr && address == 2'd3) ? (writedata & wm) : 32'h0;
      ec_n   = (m_ec[d] & ~clr) | ed;
      mask_n = (wr && address == 2'd2) ? (writedata & wm) : m_mask[d];
      case (address)
        2'd0:    rd = sq;
        2'd2:    rd = m_mask[d];
        2'd3:    rd = m_ec[d];
        default: rd = '0;
      endcase
      irq_o = |(ec_n & mask_n);
      for (int i = 3; i > 0; i--) m_sync[d][i] = m_sync[d][i-1];
      m_sync[d][0] = inp & wm;
      m_prev[d] = sq;
      m_ec[d]   = ec_n;
      m_mask[d] = mask_n;
      if (m_warm[d] > 0) m_warm[d]--;
    end
  endtask

  task automatic step();
    exp_t x;
    model_one(0, 32, 2, 0, 32'h0,  in0,          x.rd0, x.irq0);
    model_one(1, 8,  3, 2, 32'h0C, {24'h0, in1}, x.rd1, x.irq1);
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check_eq("sb_rd0",  rd0,           x.rd0);
    check_eq("sb_irq0", {31'h0, irq0}, {31'h0, x.irq0});
    check_eq("sb_rd1",  rd1,           x.rd1);
    check_eq("sb_irq1", {31'h0, irq1}, {31'h0, x.irq1});
  endtask

  task automatic idle(input int n);
    chipselect = 1'b0;
    write_n    = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_reg(input logic [1:0] a);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    step();
    chipselect = 1'b0;
  endtask

  initial begin
    // reset with inputs already high; warm-up must suppress the fake rising edge
    in0   = 32'hFFFF_FFFF;
    in1   = 8'hFF;
    reset = 1'b1;
    idle(2);
    check_eq("rst_rd0",  rd0, 32'h0);
    check_eq("rst_irq0", {31'h0, irq0}, 32'h0);
    reset   = 1'b0;
    address = 2'd0;
    idle(20);
    check_eq("warm_data0", rd0, 32'hFFFF_FFFF);
    rd_reg(2'd3);
    check_eq("warm_cap0", rd0, 32'h0);
    check_eq("warm_cap1", rd1, 32'h0);
    check_eq("warm_irq0", {31'h0, irq0}, 32'h0);

    // single-bit pulse on bit 5
    in0 = 32'h0;
    idle(4);
    wr_reg(2'd2, 32'h20);
    in0 = 32'h20;
    idle(3);
    in0 = 32'h0;
    idle(4);
    rd_reg(2'd3);
    check_eq("b5_cap", rd0, 32'h20);
    check_eq("b5_irq", {31'h0, irq0}, 32'h1);
    wr_reg(2'd3, 32'h20);
    check_eq("b5_irq_clr", {31'h0, irq0}, 32'h0);
    rd_reg(2'd3);
    check_eq("b5_cap_clr", rd0, 32'h0);

    // masked edges on bits 0 and 31, then unmask bit 0
    wr_reg(2'd2, 32'h0);
    in0 = 32'h8000_0001;
    idle(4);
    in0 = 32'h0;
    idle(2);
    rd_reg(2'd3);
    check_eq("edge_0_31", rd0, 32'h8000_0001);
    check_eq("masked_irq", {31'h0, irq0}, 32'h0);
    wr_reg(2'd2, 32'h1);
    check_eq("unmask_irq", {31'h0, irq0}, 32'h1);

    // clear of bit 0 lands in the cycle a new bit-0 edge is detected
    in0 = 32'h1;
    idle(2);
    wr_reg(2'd3, 32'h1);
    check_eq("collide_irq", {31'h0, irq0}, 32'h1);
    rd_reg(2'd3);
    check_eq("collide_cap", rd0, 32'h8000_0001);

    // 8-bit any-edge instance
    in1 = 8'hA5;
    idle(4);
    in1 = 8'h5A;
    idle(4);
    rd_reg(2'd3);
    check_eq("any_cap1", rd1, 32'h0000_00FF);
    wr_reg(2'd2, 32'hFFFF_FF00);
    rd_reg(2'd2);
    check_eq("mask1_hi", rd1, 32'h0);
    rd_reg(2'd1);
    check_eq("rsvd0", rd0, 32'h0);
    check_eq("rsvd1", rd1, 32'h0);
    rd_reg(2'd0);
    check_eq("data1", rd1, 32'h0000_005A);

    // reset mid-operation with captures pending and a write in the same cycle
    wr_reg(2'd3, 32'hFFFF_FFFF);
    wr_reg(2'd2, 32'h3);
    in0 = 32'h0;
    idle(4);
    in0 = 32'h3;
    idle(4);
    rd_reg(2'd3);
    check_eq("pre_rst_cap", rd0, 32'h3);
    check_eq("pre_rst_irq", {31'h0, irq0}, 32'h1);
    reset      = 1'b1;
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 2'd2;
    writedata  = 32'hFF;
    step();
    reset = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    check_eq("mid_rst_irq", {31'h0, irq0}, 32'h0);
    check_eq("mid_rst_rd",  rd0, 32'h0);
    rd_reg(2'd3);
    check_eq("mid_rst_cap", rd0, 32'h0);
    rd_reg(2'd2);
    check_eq("mid_rst_mask0", rd0, 32'h0);
    check_eq("mid_rst_mask1", rd1, 32'h0C);
    idle(8);
    rd_reg(2'd3);
    check_eq("post_rst_cap0", rd0, 32'h0);
    check_eq("post_rst_cap1", rd1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
